adam_stream_buffer: RTL

- Parametrised elastic stream buffer; successor to the single-entry stream skid stage.
- Holds up to DEPTH beats in a circular register array.
- Fully registered in both directions: no combinational path slv→mst, and no combinational path mst.ready→slv.ready.
- Sits between ADAM_STREAM producers and consumers to break timing paths, absorb backpressure bursts and expose occupancy.

---
 rtl/adam_stream_buffer_pkg.sv | 18 +
 rtl/adam_stream_buffer_if.sv | 20 ++
 rtl/adam_stream_buffer_mem.sv | 39 +++
 rtl/adam_stream_buffer.sv | 117 +++++++++++
 4 files changed

// File: rtl/adam_stream_buffer_pkg.sv
// adam_stream_pkg
// Shared definitions for the ADAM stream buffer slice.
//   ADAM_STREAM_BUFFER_MAX_DEPTH : largest legal DEPTH of adam_stream_buffer
//   adam_stream_ptr_inc()        : wrap-aware pointer increment, ptr in 0..depth-1
package adam_stream_pkg;

    localparam int unsigned ADAM_STREAM_BUFFER_MAX_DEPTH = 256;

    // Pointers wrap from depth-1 back to 0, so depth does not have to be a
    // power of two.
    function automatic int unsigned adam_stream_ptr_inc(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/adam_stream_buffer_if.sv
// adam_stream_buffer_if
// Valid/ready stream bundle used on both sides of adam_stream_buffer.
//   data  : payload of type data_t
//   valid : producer offers a beat
//   ready : consumer accepts a beat
// Modports:
//   master : drives data/valid, observes ready
//   slave  : observes data/valid, drives ready
interface adam_stream_buffer_if #(
    parameter type data_t = logic
);

    data_t data;
    logic  valid;
    logic  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/adam_stream_buffer_mem.sv
// adam_stream_buffer_mem
// Storage array for adam_stream_buffer: one synchronous write port and one
// combinational read port; every entry clears to zero on reset.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   we       : write enable
//   waddr    : write index (0..DEPTH-1)
//   wdata    : write payload
//   raddr    : read index (0..DEPTH-1)
//   rdata    : payload stored at raddr
module adam_stream_buffer_mem #(
    parameter type data_t    = logic,
    parameter int  DEPTH     = 2,
    parameter int  PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  data_t                wdata,
    input  logic [PTR_WIDTH-1:0] raddr,
    output data_t                rdata
);

    data_t mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adam_stream_buffer.sv
// adam_stream_buffer
// Elastic FIFO stream buffer of DEPTH entries with registered slv.ready,
// mst.valid and level; no combinational path from slv to mst or from
// mst.ready to slv.ready. A beat pushed on one edge is visible on mst after
// that edge; sustained throughput is one beat per cycle.
// Parameters:
//   data_t      : payload type
//   DEPTH       : number of entries, 2..ADAM_STREAM_BUFFER_MAX_DEPTH
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : (only with ADAM_STREAM_BUFFER_FLUSH_EN) empties the buffer
//                 at the next edge, overriding any push/pop in that cycle
//   slv         : incoming stream (slave modport)
//   mst         : outgoing stream (master modport), data read from storage
//   level       : current occupancy 0..DEPTH
// Optional feature macro: ADAM_STREAM_BUFFER_FLUSH_EN
module adam_stream_buffer
    import adam_stream_pkg::*;
#(
    parameter type data_t = logic,
    parameter int  DEPTH  = 2,
    localparam int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef ADAM_STREAM_BUFFER_FLUSH_EN
    input  logic                   flush,
`endif
    adam_stream_buffer_if.slave    slv,
    adam_stream_buffer_if.master   mst,
    output logic [LEVEL_WIDTH-1:0] level
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || DEPTH > ADAM_STREAM_BUFFER_MAX_DEPTH) begin : g_bad_depth
            $error("adam_stream_buffer: DEPTH must be within 2..256");
        end
    endgenerate

    logic [PTR_WIDTH-1:0]   wr_ptr, wr_ptr_next;
    logic [PTR_WIDTH-1:0]   rd_ptr, rd_ptr_next;
    logic [LEVEL_WIDTH-1:0] count, count_next;
    logic                   ready_q, valid_q;
    logic                   push, pop, write_en;
    data_t                  rdata;

    assign push = slv.valid && ready_q;
    assign pop  = valid_q && mst.ready;

    // Next-state for pointers and occupancy; a flush overrides everything so
    // that beats offered in the flush cycle are neither stored nor consumed.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        write_en    = push;
        if (push) begin
            wr_ptr_next = PTR_WIDTH'(adam_stream_ptr_inc(32'(wr_ptr), DEPTH));
        end
        if (pop) begin
            rd_ptr_next = PTR_WIDTH'(adam_stream_ptr_inc(32'(rd_ptr), DEPTH));
        end
        unique case ({push, pop})
            2'b10:   count_next = count + LEVEL_WIDTH'(1);
            2'b01:   count_next = count - LEVEL_WIDTH'(1);
            default: count_next = count;
        endcase
`ifdef ADAM_STREAM_BUFFER_FLUSH_EN
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            write_en    = 1'b0;
        end
`endif
    end

    // Handshake flags are registered from next-state occupancy, which keeps
    // both ready and valid free of combinational paths through the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            count   <= count_next;
            ready_q <= (count_next < LEVEL_WIDTH'(DEPTH));
            valid_q <= (count_next != '0);
        end
    end

    adam_stream_buffer_mem #(
        .data_t    (data_t),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (write_en),
        .waddr (wr_ptr),
        .wdata (slv.data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign slv.ready = ready_q;
    assign mst.valid = valid_q;
    assign mst.data  = rdata;
    assign level     = count;

endmodule
